hazard_control_unit: RTL and testbench

Stall/flush controller for the five-stage 16-bit pipeline: the producer-side counterpart to operand forwarding. It detects the hazards that forwarding cannot resolve: load-use, shared instruction/data RAM conflict, taken-branch redirect and data-memory wait states. It drives the write-enable, flush and bubble controls of PC, IF/ID and ID/EX, and a global freeze. It also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_control_unit.sv | 102 ++++++++++
 tb/tb_hazard_control_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the five-stage pipeline: load-use, shared-RAM,
// branch-redirect and memory-wait handling, plus a saturating stall counter.
module hazard_control_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       Rx_a_IFID,
   input  logic [2:0]       Ry_a_IFID,
   input  logic             useRx_a_IFID,
   input  logic             useRy_a_IFID,
   input  logic             readSpecReg_a_IFID,
   input  logic             memRead_a_IDEX,
   input  logic             regWrite_a_IDEX,
   input  logic             writeSpecReg_a_IDEX,
   input  logic [2:0]       registerToWriteId_a_IDEX,
   input  logic             branchTaken_a_IDEX,
   input  logic             memAccess_a_EXMEM,
   input  logic             memReady,
   output logic             pcWrite,
   output logic             ifidWrite,
   output logic             ifidFlush,
   output logic             idexBubble,
   output logic             pipeFreeze,
   output logic [CNT_W-1:0] stallCycles
);

   typedef enum logic {ST_RUN, ST_WAIT} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             load_use, struct_hz, mem_wait, freeze;

   always_comb begin
      load_use  = memRead_a_IDEX &
                  ((regWrite_a_IDEX &
                    ((useRx_a_IFID & (Rx_a_IFID == registerToWriteId_a_IDEX)) |
                     (useRy_a_IFID & (Ry_a_IFID == registerToWriteId_a_IDEX)))) |
                   (writeSpecReg_a_IDEX & readSpecReg_a_IFID));
      struct_hz = memAccess_a_EXMEM;
      mem_wait  = memAccess_a_EXMEM & ~memReady;
      // In WAIT the pipeline keeps memAccess high, so only memReady matters.
      freeze    = (state_q == ST_RUN) ? mem_wait : ~memReady;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:  if (mem_wait) state_d = ST_WAIT;
         ST_WAIT: if (memReady) state_d = ST_RUN;
         default: state_d = ST_RUN;
      endcase
   end

   always_comb begin
      pcWrite    = 1'b1;
      ifidWrite  = 1'b1;
      ifidFlush  = 1'b0;
      idexBubble = 1'b0;
      pipeFreeze = 1'b0;
      if (rst) begin
         pcWrite    = 1'b0;
         ifidWrite  = 1'b0;
         ifidFlush  = 1'b1;
         idexBubble = 1'b1;
      end else if (freeze) begin
         pcWrite    = 1'b0;
         ifidWrite  = 1'b0;
         pipeFreeze = 1'b1;
      end else if (branchTaken_a_IDEX) begin
         ifidFlush  = 1'b1;
         idexBubble = 1'b1;
      end else if (load_use) begin
         pcWrite    = 1'b0;
         ifidWrite  = 1'b0;
         idexBubble = 1'b1;
      end else if (struct_hz) begin
         // Fetch lost the RAM port: IF/ID takes a NOP instead.
         pcWrite    = 1'b0;
         ifidFlush  = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!pcWrite && (stall_cnt_q != {CNT_W{1'b1}}))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stallCycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: directed table, hand-written multi-cycle
// sequences and randomized traffic against a rule-level reference model.
module tb_hazard_control_unit;

   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic             clk = 1'b0;
   logic             rst;
   logic [2:0]       rx, ry, rd;
   logic             urx, ury, rspec, mrd, rw, wspec, br, macc, mrdy;
   logic             pcWrite, ifidWrite, ifidFlush, idexBubble, pipeFreeze;
   logic [CNT_W-1:0] stallCycles;

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct {
      logic [2:0] rx, ry, rd;
      logic       urx, ury, rspec, mrd, rw, wspec, br, macc, mrdy, rst;
      logic [4:0] exp;   // {pcWrite, ifidWrite, ifidFlush, idexBubble, pipeFreeze}
   } vec_t;

   // Reference model state: "a memory wait is in progress" and the stall tally.
   bit               m_waiting;
   logic [CNT_W-1:0] m_cnt;

   hazard_control_unit #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .Rx_a_IFID(rx), .Ry_a_IFID(ry),
      .useRx_a_IFID(urx), .useRy_a_IFID(ury),
      .readSpecReg_a_IFID(rspec),
      .memRead_a_IDEX(mrd), .regWrite_a_IDEX(rw),
      .writeSpecReg_a_IDEX(wspec),
      .registerToWriteId_a_IDEX(rd),
      .branchTaken_a_IDEX(br),
      .memAccess_a_EXMEM(macc), .memReady(mrdy),
      .pcWrite(pcWrite), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
      .idexBubble(idexBubble), .pipeFreeze(pipeFreeze),
      .stallCycles(stallCycles)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input logic [2:0] a_rx, input logic [2:0] a_ry,
                               input logic a_urx, input logic a_ury, input logic a_rspec,
                               input logic a_mrd, input logic a_rw, input logic a_wspec,
                               input logic [2:0] a_rd, input logic a_br, input logic a_macc,
                               input logic a_mrdy, input logic a_rst, input logic [4:0] a_exp);
      vec_t v;
      v.rx = a_rx; v.ry = a_ry; v.urx = a_urx; v.ury = a_ury; v.rspec = a_rspec;
      v.mrd = a_mrd; v.rw = a_rw; v.wspec = a_wspec; v.rd = a_rd; v.br = a_br;
      v.macc = a_macc; v.mrdy = a_mrdy; v.rst = a_rst; v.exp = a_exp;
      return v;
   endfunction

   // Priority list applied directly to the hazard rules.
   function automatic logic [4:0] model_out(input vec_t v, input bit waiting);
      bit gp_hit, sp_hit, lu, frz;
      if (v.rst) return 5'b00110;
      gp_hit = v.rw && ((v.urx && v.rx == v.rd) || (v.ury && v.ry == v.rd));
      sp_hit = v.wspec && v.rspec;
      lu     = v.mrd && (gp_hit || sp_hit);
      frz    = waiting ? !v.mrdy : (v.macc && !v.mrdy);
      if (frz)  return 5'b00001;
      if (v.br) return 5'b11110;
      if (lu)   return 5'b00010;
      if (v.macc) return 5'b01100;
      return 5'b11000;
   endfunction

   task automatic check_out(input string name, input logic [4:0] exp);
      logic [4:0] got, mask;
      got  = {pcWrite, ifidWrite, ifidFlush, idexBubble, pipeFreeze};
      // ifidWrite is irrelevant whenever IF/ID is flushed.
      mask = exp[2] ? 5'b10111 : 5'b11111;
      total_cnt++;
      if ((got & mask) == (exp & mask)) pass_cnt++;
      else $display("FAIL %s outputs{pc,ifw,fl,bub,frz}: got %b expected %b", name, got, exp);
   endtask

   task automatic check_cnt(input string name, input logic [CNT_W-1:0] exp);
      total_cnt++;
      if (stallCycles == exp) pass_cnt++;
      else $display("FAIL %s stallCycles: got %0d expected %0d", name, stallCycles, exp);
   endtask

   // One pipeline cycle: drive, check mid-cycle, advance model, cross the edge.
   task automatic step(input vec_t v, input bit use_tbl, input string name);
      logic [4:0] e;
      bit frz;
      rx = v.rx; ry = v.ry; urx = v.urx; ury = v.ury; rspec = v.rspec;
      mrd = v.mrd; rw = v.rw; wspec = v.wspec; rd = v.rd; br = v.br;
      macc = v.macc; mrdy = v.mrdy; rst = v.rst;
      #3;
      e = model_out(v, m_waiting);
      check_out(name, use_tbl ? v.exp : e);
      check_cnt(name, m_cnt);
      frz = e[0];
      if (v.rst) begin
         m_waiting = 0;
         m_cnt     = '0;
      end else begin
         m_waiting = frz;
         if (!e[4] && m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
      end
      @(posedge clk); #1;
   endtask

   vec_t tbl[17];
   vec_t idle, v;

   initial begin
      idle = mk(0,0,0,0,0,0,0,0,0,0,0,0,0,5'b11000);
      rx = 0; ry = 0; rd = 0; urx = 0; ury = 0; rspec = 0; mrd = 0; rw = 0;
      wspec = 0; br = 0; macc = 0; mrdy = 0; rst = 1;
      @(posedge clk); #1;
      m_waiting = 0; m_cnt = '0;

      //            rx ry urx ury rsp mrd rw wsp rd br mac rdy rst exp
      tbl[0]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 5'b00110); // reset outputs
      tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000); // idle
      tbl[2]  = mk(3, 0, 1, 0, 0, 1, 1, 0, 3, 0, 0, 0, 0, 5'b00010); // load-use Rx
      tbl[3]  = mk(3, 0, 0, 0, 0, 1, 1, 0, 3, 0, 0, 0, 0, 5'b11000); // Rx not used
      tbl[4]  = mk(1, 5, 0, 1, 0, 1, 1, 0, 5, 0, 0, 0, 0, 5'b00010); // load-use Ry
      tbl[5]  = mk(3, 0, 1, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 5'b11000); // not a load
      tbl[6]  = mk(1, 2, 1, 1, 1, 1, 0, 1, 6, 0, 0, 0, 0, 5'b00010); // special-reg load-use
      tbl[7]  = mk(1, 2, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0, 5'b11000); // spec write, no spec read
      tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b01100); // structural only
      tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b11110); // branch alone
      tbl[10] = mk(4, 0, 1, 0, 0, 1, 1, 0, 4, 1, 1, 1, 0, 5'b11110); // branch beats lu+struct
      tbl[11] = mk(4, 0, 1, 0, 0, 1, 1, 0, 4, 0, 1, 1, 0, 5'b00010); // lu beats struct
      tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00001); // freeze, enter wait
      tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 5'b00001); // freeze beats branch
      tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b01100); // ready: struct applies
      tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000); // back in run
      tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000);
      foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("tbl%0d", i));

      // Three wait cycles then ready: 4 stall cycles added.
      v = idle; v.rst = 1; step(v, 1'b0, "seq_wait_rst");
      v = idle; v.macc = 1; v.mrdy = 0; v.exp = 5'b00001;
      for (int i = 0; i < 3; i++) step(v, 1'b1, $sformatf("seq_wait%0d", i));
      v.mrdy = 1; v.exp = 5'b01100; step(v, 1'b1, "seq_wait_done");
      check_cnt("seq_wait_total", 4'd4);
      step(idle, 1'b1, "seq_wait_run");

      // Reset during a wait returns to RUN with a cleared counter.
      v = idle; v.macc = 1; v.mrdy = 0; v.exp = 5'b00001;
      step(v, 1'b1, "seq_rw_enter");
      step(v, 1'b1, "seq_rw_hold");
      v.rst = 1; v.exp = 5'b00110; step(v, 1'b1, "seq_rw_reset");
      check_cnt("seq_rw_cleared", 4'd0);
      step(idle, 1'b1, "seq_rw_run");

      // Saturation: 2^CNT_W + 5 structural stalls.
      v = idle; v.macc = 1; v.mrdy = 1; v.exp = 5'b01100;
      for (int i = 0; i < (1 << CNT_W) + 5; i++) step(v, 1'b1, "seq_sat");
      check_cnt("seq_sat_hold", CNT_MAX);
      step(idle, 1'b1, "seq_sat_run");
      check_cnt("seq_sat_after", CNT_MAX);

      // Randomized traffic; memAccess stays high while a wait is pending.
      for (int i = 0; i < 600; i++) begin
         v.rx    = 3'($urandom_range(0, 7));
         v.ry    = 3'($urandom_range(0, 7));
         v.rd    = ($urandom_range(0, 1) == 1) ? v.rx : 3'($urandom_range(0, 7));
         v.urx   = 1'($urandom_range(0, 1));
         v.ury   = 1'($urandom_range(0, 1));
         v.rspec = 1'($urandom_range(0, 1));
         v.mrd   = 1'($urandom_range(0, 1));
         v.rw    = 1'($urandom_range(0, 1));
         v.wspec = 1'($urandom_range(0, 1));
         v.br    = ($urandom_range(0, 5) == 0);
         v.macc  = m_waiting ? 1'b1 : ($urandom_range(0, 3) == 0);
         v.mrdy  = 1'($urandom_range(0, 1));
         v.rst   = ($urandom_range(0, 40) == 0);
         v.exp   = 5'b0;
         step(v, 1'b0, "rand");
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
